// File: rtl/pls_seq.sv
// pls_seq: segment sequencer feeding the pulse generator.
// Holds one segment ahead so consecutive segments chain without a gap.
module pls_seq #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             abort,
  input  logic             seg_valid,
  output logic             seg_ready,
  input  logic [31:0]      seg_T,
  input  logic [CNT_W-1:0] seg_N,
  input  logic             seg_dir,
  input  logic             seg_pause,
  output logic [31:0]      T,
  output logic             dir_req,
  output logic             pause_req,
  output logic             start_clk,
  output logic             stop_clk,
  input  logic             loaded,
  input  logic             run,
  input  logic             start_rdy,
  output logic             busy,
  output logic             seg_done,
  output logic [CNT_W-1:0] steps_left,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP,
    ABORT
  } state_e;

  state_e           state_q;
  logic [31:0]      cur_T_q;
  logic             cur_dir_q;
  logic             cur_pause_q;
  logic [CNT_W-1:0] cur_left_q;
  logic [31:0]      nxt_T_q;
  logic             nxt_dir_q;
  logic             nxt_pause_q;
  logic [CNT_W-1:0] nxt_left_q;
  logic             nxt_valid_q;
  logic             stop_q;
  logic             seg_done_q;
  logic             err_q;

  logic left_nz;
  logic last;
  logic promote;
  logic accept;
  logic can_start;

  assign left_nz = cur_left_q != '0;
  assign last    = loaded && (cur_left_q == CNT_W'(1));
  assign promote = nxt_valid_q && (!left_nz || last);

  assign seg_ready = !nxt_valid_q && (state_q != ABORT) && !abort;
  assign accept    = seg_valid && seg_ready && (seg_N != '0);

  // Start only from a quiet generator; never depends on loaded.
  assign can_start = (state_q == IDLE) || (state_q == STOP);
  assign start_clk = can_start && left_nz && start_rdy && !abort;
  assign stop_clk  = stop_q && (state_q == STOP) && !abort;

  assign T          = cur_T_q;
  assign dir_req    = cur_dir_q;
  assign pause_req  = cur_pause_q;
  assign steps_left = cur_left_q;
  assign seg_done   = seg_done_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE) || left_nz || nxt_valid_q || run;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= IDLE;
      cur_T_q     <= '0;
      cur_dir_q   <= 1'b0;
      cur_pause_q <= 1'b0;
      cur_left_q  <= '0;
      nxt_T_q     <= '0;
      nxt_dir_q   <= 1'b0;
      nxt_pause_q <= 1'b0;
      nxt_left_q  <= '0;
      nxt_valid_q <= 1'b0;
      stop_q      <= 1'b0;
      seg_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else if (abort) begin
      state_q     <= ABORT;
      cur_left_q  <= '0;
      nxt_valid_q <= 1'b0;
      stop_q      <= 1'b0;
      seg_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      seg_done_q <= last;
      stop_q     <= 1'b0;

      if (loaded && !left_nz)
        err_q <= 1'b1;

      if (promote) begin
        cur_T_q     <= nxt_T_q;
        cur_dir_q   <= nxt_dir_q;
        cur_pause_q <= nxt_pause_q;
        cur_left_q  <= nxt_left_q;
      end else if (loaded && left_nz) begin
        cur_left_q <= cur_left_q - CNT_W'(1);
      end

      if (accept) begin
        nxt_T_q     <= seg_T;
        nxt_dir_q   <= seg_dir;
        nxt_pause_q <= seg_pause;
        nxt_left_q  <= seg_N;
        nxt_valid_q <= 1'b1;
      end else if (promote) begin
        nxt_valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE, STOP: begin
          // A one-period segment finishes on its own start edge.
          if (start_clk) begin
            if (last && !nxt_valid_q) begin
              state_q <= STOP;
              stop_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end else if (state_q == STOP && !run) begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (last && !nxt_valid_q) begin
            state_q <= STOP;
            stop_q  <= 1'b1;
          end
        end
        ABORT: begin
          if (!run)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pls_seq.sv
// Bench for pls_seq: cycle vectors, a small generator model,
// and an asynchronous clear in mid-segment.
module tb_pls_seq;

  logic        clk = 1'b0;
  logic        aclr = 1'b1;
  logic        abort = 1'b0;
  logic        seg_valid = 1'b0;
  logic        seg_ready;
  logic [31:0] seg_T = '0;
  logic [31:0] seg_N = '0;
  logic        seg_dir = 1'b0;
  logic        seg_pause = 1'b0;
  logic [31:0] T;
  logic        dir_req, pause_req;
  logic        start_clk, stop_clk;
  logic        loaded = 1'b0;
  logic        run = 1'b0;
  logic        start_rdy = 1'b1;
  logic        busy, seg_done, err;
  logic [31:0] steps_left;

  int errors = 0;
  int checks = 0;

  pls_seq #(.CNT_W(32)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .abort      (abort),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .seg_T      (seg_T),
    .seg_N      (seg_N),
    .seg_dir    (seg_dir),
    .seg_pause  (seg_pause),
    .T          (T),
    .dir_req    (dir_req),
    .pause_req  (pause_req),
    .start_clk  (start_clk),
    .stop_clk   (stop_clk),
    .loaded     (loaded),
    .run        (run),
    .start_rdy  (start_rdy),
    .busy       (busy),
    .seg_done   (seg_done),
    .steps_left (steps_left),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] t;
    logic [31:0] n;
    logic [1:0]  dp;
    logic        ld, rn, srdy, ab;
    logic        rdy, st, sp;
    logic [31:0] tx;
    logic        bsy, done;
    logic [31:0] left;
    logic        er;
    logic [1:0]  dpx;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic v, input logic [31:0] t, input logic [31:0] n,
    input logic [1:0] dp, input logic ld, input logic rn,
    input logic srdy, input logic ab, input logic rdy,
    input logic st, input logic sp, input logic [31:0] tx,
    input logic bsy, input logic done, input logic [31:0] left,
    input logic er, input logic [1:0] dpx);
    vec_t r;
    r.v = v; r.t = t; r.n = n; r.dp = dp;
    r.ld = ld; r.rn = rn; r.srdy = srdy; r.ab = ab;
    r.rdy = rdy; r.st = st; r.sp = sp; r.tx = tx;
    r.bsy = bsy; r.done = done; r.left = left;
    r.er = er; r.dpx = dpx;
    vq.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_row(input int i, input vec_t r);
    string s;
    s = $sformatf("row%0d", i);
    chk({s, ".seg_ready"}, 32'(seg_ready), 32'(r.rdy));
    chk({s, ".start_clk"}, 32'(start_clk), 32'(r.st));
    chk({s, ".stop_clk"}, 32'(stop_clk), 32'(r.sp));
    chk({s, ".T"}, T, r.tx);
    chk({s, ".busy"}, 32'(busy), 32'(r.bsy));
    chk({s, ".seg_done"}, 32'(seg_done), 32'(r.done));
    chk({s, ".steps_left"}, steps_left, r.left);
    chk({s, ".err"}, 32'(err), 32'(r.er));
    chk({s, ".dir_pause"}, 32'({dir_req, pause_req}), 32'(r.dpx));
  endtask

  initial begin
    int k, nld, ndone, nstop, nstart, cnt;
    logic grun, fin;
    logic [31:0] gt [2];
    logic [31:0] gn [2];

    // Single segment
    add(1,10,3,2, 0,0,1,0, 1,0,0, 0,0,0,0,0,0);
    add(0, 0,0,0, 0,0,1,0, 0,0,0, 0,1,0,0,0,0);
    add(0, 0,0,0, 1,0,1,0, 1,1,0,10,1,0,3,0,2);
    add(0, 0,0,0, 0,1,1,0, 1,0,0,10,1,0,2,0,2);
    add(0, 0,0,0, 1,1,1,0, 1,0,0,10,1,0,2,0,2);
    add(0, 0,0,0, 0,1,1,0, 1,0,0,10,1,0,1,0,2);
    add(0, 0,0,0, 1,1,1,0, 1,0,0,10,1,0,1,0,2);
    add(0, 0,0,0, 0,1,1,0, 1,0,1,10,1,1,0,0,2);
    add(0, 0,0,0, 0,1,1,0, 1,0,0,10,1,0,0,0,2);
    add(0, 0,0,0, 0,0,1,0, 1,0,0,10,1,0,0,0,2);
    add(0, 0,0,0, 0,0,1,0, 1,0,0,10,0,0,0,0,2);
    // Chaining
    add(1, 8,2,0, 0,0,1,0, 1,0,0,10,0,0,0,0,2);
    add(1,20,1,1, 0,0,1,0, 0,0,0,10,1,0,0,0,2);
    add(1,20,1,1, 1,0,1,0, 1,1,0, 8,1,0,2,0,0);
    add(0, 0,0,0, 0,1,1,0, 0,0,0, 8,1,0,1,0,0);
    add(0, 0,0,0, 1,1,1,0, 0,0,0, 8,1,0,1,0,0);
    add(0, 0,0,0, 0,1,1,0, 1,0,0,20,1,1,1,0,1);
    add(0, 0,0,0, 1,1,1,0, 1,0,0,20,1,0,1,0,1);
    add(0, 0,0,0, 0,1,1,0, 1,0,1,20,1,1,0,0,1);
    add(0, 0,0,0, 0,0,1,0, 1,0,0,20,1,0,0,0,1);
    add(0, 0,0,0, 0,0,1,0, 1,0,0,20,0,0,0,0,1);
    // Late segment while stopping
    add(1, 5,1,0, 0,0,1,0, 1,0,0,20,0,0,0,0,1);
    add(0, 0,0,0, 0,0,1,0, 0,0,0,20,1,0,0,0,1);
    add(0, 0,0,0, 1,0,1,0, 1,1,0, 5,1,0,1,0,0);
    add(1,16,2,2, 0,1,1,0, 1,0,1, 5,1,1,0,0,0);
    add(0, 0,0,0, 0,1,1,0, 0,0,0, 5,1,0,0,0,0);
    add(0, 0,0,0, 0,1,0,0, 1,0,0,16,1,0,2,0,2);
    add(0, 0,0,0, 1,1,1,0, 1,1,0,16,1,0,2,0,2);
    add(0, 0,0,0, 0,1,1,0, 1,0,0,16,1,0,1,0,2);
    add(0, 0,0,0, 1,1,1,0, 1,0,0,16,1,0,1,0,2);
    add(0, 0,0,0, 0,1,1,0, 1,0,1,16,1,1,0,0,2);
    add(0, 0,0,0, 0,0,1,0, 1,0,0,16,1,0,0,0,2);
    add(0, 0,0,0, 0,0,1,0, 1,0,0,16,0,0,0,0,2);
    // N=0, backpressure, abort with a held segment
    add(1,99,0,3, 0,0,1,0, 1,0,0,16,0,0,0,0,2);
    add(0, 0,0,0, 0,0,1,0, 1,0,0,16,0,0,0,0,2);
    add(1, 3,6,0, 0,0,0,0, 1,0,0,16,0,0,0,0,2);
    add(1, 4,7,1, 0,0,0,0, 0,0,0,16,1,0,0,0,2);
    add(1, 4,7,1, 0,0,0,0, 1,0,0, 3,1,0,6,0,0);
    add(1, 6,2,3, 0,0,0,0, 0,0,0, 3,1,0,6,0,0);
    add(1, 6,2,3, 0,0,0,0, 0,0,0, 3,1,0,6,0,0);
    add(0, 0,0,0, 1,0,1,0, 0,1,0, 3,1,0,6,0,0);
    add(0, 0,0,0, 0,1,1,0, 0,0,0, 3,1,0,5,0,0);
    add(0, 0,0,0, 1,1,1,1, 0,0,0, 3,1,0,5,0,0);
    add(1, 6,2,3, 0,1,1,0, 0,0,0, 3,1,0,0,0,0);
    add(1, 6,2,3, 0,0,1,0, 0,0,0, 3,1,0,0,0,0);
    add(0, 0,0,0, 0,0,1,0, 1,0,0, 3,0,0,0,0,0);
    // Spurious load, cleared by abort
    add(0, 0,0,0, 1,0,1,0, 1,0,0, 3,0,0,0,0,0);
    add(0, 0,0,0, 0,0,1,0, 1,0,0, 3,0,0,0,1,0);
    add(0, 0,0,0, 0,0,1,0, 1,0,0, 3,0,0,0,1,0);
    add(0, 0,0,0, 0,0,1,1, 0,0,0, 3,0,0,0,1,0);
    add(0, 0,0,0, 0,0,1,0, 0,0,0, 3,1,0,0,0,0);
    add(0, 0,0,0, 0,0,1,0, 1,0,0, 3,0,0,0,0,0);

    #3;
    chk("rst.seg_ready", 32'(seg_ready), 32'd1);
    chk("rst.T", T, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.start_stop", 32'({start_clk, stop_clk}), 32'd0);
    chk("rst.steps_left", steps_left, 32'd0);
    chk("rst.err_done", 32'({err, seg_done}), 32'd0);
    @(negedge clk);
    aclr = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      seg_valid = vq[i].v;
      seg_T     = vq[i].t;
      seg_N     = vq[i].n;
      {seg_dir, seg_pause} = vq[i].dp;
      loaded    = vq[i].ld;
      run       = vq[i].rn;
      start_rdy = vq[i].srdy;
      abort     = vq[i].ab;
      #1;
      chk_row(i, vq[i]);
    end

    // Two chained segments against a simple generator model
    @(negedge clk);
    seg_valid = 0; loaded = 0; run = 0; abort = 0; start_rdy = 1;
    gt[0] = 32'd12; gn[0] = 32'd3;
    gt[1] = 32'd9;  gn[1] = 32'd2;
    k = 0; nld = 0; ndone = 0; nstop = 0; nstart = 0;
    cnt = 0; grun = 0; fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (seg_done)  ndone++;
      if (stop_clk)  nstop++;
      if (start_clk) nstart++;
      loaded = 1'b0;
      if (!grun && start_clk) begin
        loaded = 1'b1; grun = 1'b1; cnt = 0;
      end else if (grun) begin
        if (stop_clk) grun = 1'b0;
        else begin
          cnt++;
          if (cnt == 3) begin cnt = 0; loaded = 1'b1; end
        end
      end
      run = grun;
      if (loaded) nld++;
      seg_valid = (k < 2);
      if (k < 2) begin
        seg_T = gt[k]; seg_N = gn[k]; seg_dir = 1'b1; seg_pause = 1'b0;
        if (seg_ready) k++;
      end
      #1;
      if (k == 2 && !busy) fin = 1'b1;
    end
    seg_valid = 0; loaded = 0; run = 0;
    chk("gen.finished", 32'(fin), 32'd1);
    chk("gen.loaded", 32'(nld), 32'd5);
    chk("gen.seg_done", 32'(ndone), 32'd2);
    chk("gen.stop_clk", 32'(nstop), 32'd1);
    chk("gen.start_clk", 32'(nstart), 32'd1);
    chk("gen.err", 32'(err), 32'd0);
    chk("gen.T", T, 32'd9);

    // Asynchronous clear mid-segment
    @(negedge clk);
    seg_valid = 1; seg_T = 32'd7; seg_N = 32'd4;
    seg_dir = 1; seg_pause = 1;
    @(negedge clk);
    seg_valid = 0;
    @(negedge clk);
    #1;
    chk("pre_aclr.steps_left", steps_left, 32'd4);
    chk("pre_aclr.start_clk", 32'(start_clk), 32'd1);
    #1;
    aclr = 1'b1;
    #1;
    chk("aclr.T", T, 32'd0);
    chk("aclr.steps_left", steps_left, 32'd0);
    chk("aclr.busy", 32'(busy), 32'd0);
    chk("aclr.seg_ready", 32'(seg_ready), 32'd1);
    chk("aclr.start_clk", 32'(start_clk), 32'd0);
    chk("aclr.dir_pause", 32'({dir_req, pause_req}), 32'd0);
    @(negedge clk);
    aclr = 1'b0;
    @(negedge clk);
    #1;
    chk("post_aclr.busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pls_seq.md
# pls_seq

Segment sequencer directly upstream of the pulse generator. It accepts motion segments (period `T`, period count `N`, direction, pause flag) over a valid/ready port and buffers one segment ahead. It drives the generator's start/stop/T/dir/pause inputs and counts generator `loaded` strobes, so consecutive segments chain without a gap and the generator is stopped cleanly after the last period.

## Interface
Parameters:
- `CNT_W`, default 32: width of `seg_N` and `steps_left`.

Ports:
- `clk` in 1: clock.
- `aclr` in 1: reset, asynchronous, active-high.
- `abort` in 1: shared abort, same net as the generator's `abort`.
- `seg_valid` in 1: segment offered.
- `seg_ready` out 1: segment accepted when `seg_valid && seg_ready`.
- `seg_T` in 32: period in clocks, passed through unclamped.
- `seg_N` in CNT_W: number of periods; 0 means accept and discard.
- `seg_dir` in 1: direction.
- `seg_pause` in 1: pause segment.
- `T` out 32: to generator.
- `dir_req` out 1: to generator.
- `pause_req` out 1: to generator.
- `start_clk` out 1: to generator.
- `stop_clk` out 1: to generator.
- `loaded` in 1: from generator; one strobe per period started.
- `run` in 1: from generator.
- `start_rdy` in 1: from generator.
- `busy` out 1: sequencer or generator active, or a segment is held.
- `seg_done` out 1: one-cycle pulse when the last period of a segment is loaded.
- `steps_left` out CNT_W: periods of the current segment not yet loaded.
- `err` out 1: sticky; `loaded` seen while no period is owed.

## Operation
Storage:
- Current registers `cur_T/cur_dir/cur_pause/cur_left`; next registers `nxt_*` plus `nxt_valid`.
- `T`, `dir_req` and `pause_req` are driven directly from the `cur_*` registers.
- `steps_left = cur_left`.
- `seg_ready = !nxt_valid && state != ABORT && !abort`.
- An accepted segment with N != 0 is written to `nxt`. N = 0 is dropped: no state change, no `seg_done`.

Promotion `nxt -> cur` (clears `nxt_valid`) happens at an edge where either:
- `cur_left == 0`, or
- `loaded && cur_left == 1`.

Each `loaded` while `cur_left != 0` decrements `cur_left`. If `loaded` arrives while `cur_left == 0`, `err` is set.

FSM states:
- **IDLE**:
  - `start_clk = (cur_left != 0) && start_rdy && !abort`, combinational from registers and `start_rdy` only, never from `loaded`.
  - On `start_clk`, go to RUN. The generator loads in the same cycle, so the decrement applies at that edge.
- **RUN**:
  - If `loaded && cur_left == 1 && !nxt_valid`, go to STOP.
  - Otherwise stay; chaining happens by promotion.
- **STOP**:
  - `stop_clk = 1` in the first STOP cycle only (registered flag).
  - If `cur_left != 0` (a new segment was promoted) and `start_rdy`, assert `start_clk` and go to RUN.
  - Else if `!run`, go to IDLE.
- **ABORT**: entered from any state when `abort = 1`.
  - Flush `cur_left`, `nxt_valid` and the stop flag.
  - `start_clk = stop_clk = 0`.
  - Return to IDLE in the first cycle with `!abort && !run`.

Outputs and flags:
- `seg_done` is registered, high for one cycle after the edge at which `loaded` meets `cur_left == 1`.
- `busy = state != IDLE || cur_left != 0 || nxt_valid || run`.
- `err` is cleared only by `aclr` or `abort`.

## Timing
- Reset values: `seg_ready = 1`, `start_clk = stop_clk = 0`, `T = 0`, `dir_req = pause_req = 0`, `busy = 0`, `seg_done = 0`, `steps_left = 0`, `err = 0`, state IDLE.
- Accept-to-start latency from idle:
  - Accept at edge E0 sets `nxt_valid`.
  - Promotion at E1.
  - `start_clk` is high during the cycle after E1 if `start_rdy`; the earliest first `loaded` is therefore 2 cycles after acceptance.
- Chaining: the new `T/dir/pause` are visible from the edge of the last old `loaded`. The generator never sees a gap or a `stop_clk`.
- Accept and promote in the same cycle: the accept writes `nxt` while the promotion reads the old `nxt`. This cannot occur with valid data because `seg_ready = 0` whenever `nxt_valid = 1`.
- `abort` is synchronous and has priority over accept, promote, decrement and `start_clk` in the same cycle.
- `aclr` mid-segment returns everything to the reset values immediately.

## Test plan
- **Single segment.** T=10, N=3, dir=1 → one `start_clk`, exactly 3 `loaded`, `seg_done` after the 3rd, one `stop_clk` pulse, IDLE once `run=0`, `steps_left` 3→2→1→0.
- **Chaining.** T=8,N=2 then T=20,N=1 queued before the first ends → `T` switches to 20 at the edge of the 2nd `loaded`, no `stop_clk` between segments, one `start_clk` total, two `seg_done` pulses.
- **Late segment in STOP.** Segment A (N=1) finishes and `stop_clk` pulses; segment B (T=16, N=2) arrives while `run=1` → `start_clk` when `start_rdy`, state RUN, 2 further `loaded`.
- **N=0 and backpressure.** Offer N=0 → accepted, no `start_clk`, `busy=0`. Offer three segments back-to-back → `seg_ready` drops after the 2nd until promotion.
- **Abort mid-segment.** Pulse `abort` with `cur_left=5` and a next segment held → `cur_left=0`, `nxt_valid=0`, `seg_ready=0` until `run` falls, then IDLE and `seg_ready=1`.
- **Spurious load.** `loaded` forced in IDLE with `cur_left=0` → `err=1` and held; cleared by `abort`.
